// File: rtl/sum_pkg.sv
// Shared types and defaults for the 1-to-N summation controller.
package sum_pkg;

  localparam int unsigned DATA_W_DEF     = 16;
  localparam int unsigned TMO_W_DEF      = 8;
  localparam int unsigned TMO_CYCLES_DEF = 200;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    RUN     = 3'd2,
    DRAIN   = 3'd3,
    CAPTURE = 3'd4,
    HOLD    = 3'd5
  } state_e;

endpackage

// File: rtl/sum_watchdog.sv
// Saturating cycle counter with clear, enable, zero and expiry flags.
module sum_watchdog #(
  parameter int unsigned W     = 8,
  parameter int unsigned LIMIT = 200
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic zero,
  output logic expired
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero    = (cnt_q == '0);
  // Flags the last allowed cycle so the exit lands exactly on LIMIT cycles.
  assign expired = (cnt_q >= W'(LIMIT - 1));

endmodule

// File: rtl/sum_ctrl.sv
// Sequencing controller for the summation datapath: strobes, result capture,
// valid/ready output, watchdog timeout, abort and sticky error.
module sum_ctrl
  import sum_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned TMO_W      = TMO_W_DEF,
  parameter int unsigned TMO_CYCLES = TMO_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              ld_sum,
  output logic              ld_counter,
  output logic              en_sum,
  output logic              en_counter,
  input  logic              dp_done,
  input  logic [DATA_W-1:0] dp_result,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              err
);

  state_e            state_q, state_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic              busy_q, busy_d;
  logic              ld_q, ld_d;
  logic              en_q, en_d;
  logic              valid_q, valid_d;
  logic              wd_zero, wd_expired;

  // Watchdog is zero only in the first RUN cycle, which doubles as the stale-done mask.
  sum_watchdog #(
    .W     (TMO_W),
    .LIMIT (TMO_CYCLES)
  ) u_wdog (
    .clk     (clk),
    .rst_n   (rst),
    .clr     (state_q == CLEAR),
    .en      (state_q == RUN),
    .zero    (wd_zero),
    .expired (wd_expired)
  );

  always_comb begin
    state_d    = state_q;
    err_d      = err_q;
    res_data_d = res_data_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CLEAR;
          err_d   = 1'b0;
        end
      end
      CLEAR:   state_d = RUN;
      RUN: begin
        if (dp_done && !wd_zero) begin
          state_d = DRAIN;
        end else if (wd_expired) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      DRAIN:   state_d = CAPTURE;
      CAPTURE: begin
        state_d = HOLD;
        if (!abort) res_data_d = dp_result;
      end
      HOLD: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Abort overrides the next state but never the error flag set above.
    if (abort && (state_q inside {CLEAR, RUN, DRAIN, CAPTURE})) begin
      state_d = IDLE;
    end
  end

  // Outputs are registered from the next state so they align with their state.
  always_comb begin
    busy_d  = (state_d != IDLE);
    ld_d    = (state_d == CLEAR);
    en_d    = (state_d == RUN);
    valid_d = (state_d == HOLD);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      err_q      <= 1'b0;
      res_data_q <= '0;
      busy_q     <= 1'b0;
      ld_q       <= 1'b0;
      en_q       <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      err_q      <= err_d;
      res_data_q <= res_data_d;
      busy_q     <= busy_d;
      ld_q       <= ld_d;
      en_q       <= en_d;
      valid_q    <= valid_d;
    end
  end

  assign busy       = busy_q;
  assign ld_sum     = ld_q;
  assign ld_counter = ld_q;
  assign en_sum     = en_q;
  assign en_counter = en_q;
  assign res_valid  = valid_q;
  assign res_data   = res_data_q;
  assign err        = err_q;

endmodule
